// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: 4-slot time-division scheduler for the shared VRAM.
// Slots 0-2 fetch name/pattern/attribute bytes, slot 3 serves the CPU port.
module vram_slot_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slot_en,
    input  logic                  disp_en,
    output logic [1:0]            slot,
    input  logic [ADDR_WIDTH-1:0] name_addr,
    input  logic [ADDR_WIDTH-1:0] pat_addr,
    input  logic [ADDR_WIDTH-1:0] attr_addr,
    output logic [DATA_WIDTH-1:0] name_data,
    output logic [DATA_WIDTH-1:0] pat_data,
    output logic [DATA_WIDTH-1:0] attr_data,
    output logic                  name_vld,
    output logic                  pat_vld,
    output logic                  attr_vld,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_NAME = 3'd1;
    localparam logic [2:0] K_PAT  = 3'd2;
    localparam logic [2:0] K_ATTR = 3'd3;
    localparam logic [2:0] K_CRD  = 3'd4;
    localparam logic [2:0] K_CWR  = 3'd5;

    logic [1:0]            cnt;
    logic                  disp_lat;
    logic                  in_flight;
    logic [2:0]            tag_issue;
    logic [2:0]            tag_ram;
    logic                  disp_slot;
    logic                  issue_disp;
    logic                  grant;
    logic [2:0]            issue_kind;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign disp_slot  = disp_lat && (cnt != 2'd3);
    assign issue_disp = slot_en && disp_slot;
    // The ack clk blocks a grant so a held req cannot re-issue the same access.
    assign grant = slot_en && !disp_slot && cpu_req
                   && !in_flight && !cpu_ack;

    always_comb begin
        issue_kind = K_NONE;
        issue_addr = cpu_addr;
        unique case (1'b1)
            issue_disp: begin
                case (cnt)
                    2'd0: begin
                        issue_kind = K_NAME;
                        issue_addr = name_addr;
                    end
                    2'd1: begin
                        issue_kind = K_PAT;
                        issue_addr = pat_addr;
                    end
                    default: begin
                        issue_kind = K_ATTR;
                        issue_addr = attr_addr;
                    end
                endcase
            end
            grant: begin
                issue_kind = cpu_we ? K_CWR : K_CRD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 2'd0;
            slot      <= 2'd0;
            disp_lat  <= 1'b0;
            in_flight <= 1'b0;
            tag_issue <= K_NONE;
            tag_ram   <= K_NONE;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            name_data <= '0;
            pat_data  <= '0;
            attr_data <= '0;
            name_vld  <= 1'b0;
            pat_vld   <= 1'b0;
            attr_vld  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            name_vld  <= 1'b0;
            pat_vld   <= 1'b0;
            attr_vld  <= 1'b0;
            cpu_ack   <= 1'b0;
            ram_we    <= 1'b0;
            tag_issue <= issue_kind;
            tag_ram   <= tag_issue;

            if (slot_en) begin
                cnt  <= cnt + 2'd1;
                slot <= cnt;
                if (cnt == 2'd3) begin
                    disp_lat <= disp_en;
                end
            end

            if (issue_disp || grant) begin
                ram_addr <= issue_addr;
            end
            if (grant) begin
                ram_we    <= cpu_we;
                ram_wdata <= cpu_wdata;
                in_flight <= 1'b1;
            end

            case (tag_ram)
                K_NAME: begin
                    name_data <= ram_rdata;
                    name_vld  <= 1'b1;
                end
                K_PAT: begin
                    pat_data <= ram_rdata;
                    pat_vld  <= 1'b1;
                end
                K_ATTR: begin
                    attr_data <= ram_rdata;
                    attr_vld  <= 1'b1;
                end
                K_CRD: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ack   <= 1'b1;
                    in_flight <= 1'b0;
                end
                K_CWR: begin
                    cpu_ack   <= 1'b1;
                    in_flight <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed checks of slot order, fetch latency,
// CPU handshake and display-enable timing against a behavioural VRAM.
module tb_vram_slot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        slot_en;
    logic        disp_en;
    logic [1:0]  slot;
    logic [14:0] name_addr;
    logic [14:0] pat_addr;
    logic [14:0] attr_addr;
    logic [7:0]  name_data;
    logic [7:0]  pat_data;
    logic [7:0]  attr_data;
    logic        name_vld;
    logic        pat_vld;
    logic        attr_vld;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int total = 0;
    int bad   = 0;
    int nxt   = 0;

    logic [7:0] mem [0:32767];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    vram_slot_arbiter #(
        .ADDR_WIDTH(15),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .slot_en   (slot_en),
        .disp_en   (disp_en),
        .slot      (slot),
        .name_addr (name_addr),
        .pat_addr  (pat_addr),
        .attr_addr (attr_addr),
        .name_data (name_data),
        .pat_data  (pat_data),
        .attr_data (attr_data),
        .name_vld  (name_vld),
        .pat_vld   (pat_vld),
        .attr_vld  (attr_vld),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic step();
        @(negedge clk);
        if (slot_en) nxt = (nxt + 1) % 4;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8 && nxt != s; i++) step();
    endtask

    task automatic test_reset();
        logic [39:0] v1;
        logic [26:0] v2;
        int ack_seen;
        reset = 1'b0;
        slot_en = 1'b0;
        disp_en = 1'b0;
        name_addr = '0;
        pat_addr = '0;
        attr_addr = '0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        slot_en = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 15'h7fff;
        cpu_wdata = 8'h5a;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        v1 = {slot, ram_we, ram_addr, ram_wdata,
              cpu_ack, cpu_rdata, 5'd0};
        total++;
        if (v1 !== 40'd0) begin
            bad++;
            $display("FAIL reset_cpu_ram: got %h want 0", v1);
        end
        v2 = {name_data, pat_data, attr_data,
              name_vld, pat_vld, attr_vld};
        total++;
        if (v2 !== 27'd0) begin
            bad++;
            $display("FAIL reset_disp: got %h want 0", v2);
        end
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        slot_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        slot_en = 1'b1;
        nxt = 0;
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_ack) ack_seen = 1;
            total++;
            if (slot !== 2'(i % 4)) begin
                bad++;
                $display("FAIL slot_seq[%0d]: got %0d want %0d",
                         i, slot, i % 4);
            end
        end
        total++;
        if (ack_seen != 0) begin
            bad++;
            $display("FAIL dropped_ack: got ack want none");
        end
    endtask

    task automatic test_display();
        disp_en = 1'b1;
        name_addr = 15'h0100;
        pat_addr = 15'h2208;
        attr_addr = 15'h4100;
        wait_slot(3);
        step();
        step();
        total++;
        if (slot !== 2'd0 || ram_addr !== 15'h0100 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL name_issue: got slot %0d addr %h we %b want 0 0100 0",
                     slot, ram_addr, ram_we);
        end
        total++;
        if (name_vld !== 1'b0) begin
            bad++;
            $display("FAIL name_vld_early: got %b want 0", name_vld);
        end
        step();
        total++;
        if (ram_addr !== 15'h2208) begin
            bad++;
            $display("FAIL pat_issue: got %h want 2208", ram_addr);
        end
        step();
        total++;
        if (name_vld !== 1'b1 || name_data !== 8'h41) begin
            bad++;
            $display("FAIL name_fetch: got vld %b data %h want 1 41",
                     name_vld, name_data);
        end
        step();
        total++;
        if (pat_vld !== 1'b1 || pat_data !== 8'h3c || name_vld !== 1'b0) begin
            bad++;
            $display("FAIL pat_fetch: got vld %b data %h nvld %b want 1 3c 0",
                     pat_vld, pat_data, name_vld);
        end
        step();
        total++;
        if (attr_vld !== 1'b1 || attr_data !== 8'h1f) begin
            bad++;
            $display("FAIL attr_fetch: got vld %b data %h want 1 1f",
                     attr_vld, attr_data);
        end
    endtask

    task automatic test_cpu_write_read();
        int we_cnt;
        int we_at;
        int ack_at;
        int got;
        logic [14:0] we_addr;
        logic [7:0] we_data;
        logic [1:0] we_slot;
        we_cnt = 0;
        we_at = -1;
        ack_at = -1;
        we_addr = '0;
        we_data = '0;
        we_slot = '0;
        wait_slot(0);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 15'h1234;
        cpu_wdata = 8'ha5;
        for (int i = 0; i < 7; i++) begin
            step();
            if (ram_we) begin
                we_cnt++;
                we_at = i;
                we_addr = ram_addr;
                we_data = ram_wdata;
                we_slot = slot;
            end
            if (cpu_ack && ack_at < 0) begin
                ack_at = i;
                cpu_req = 1'b0;
                cpu_we = 1'b0;
            end
        end
        total++;
        if (we_cnt != 1 || we_at != 3 || we_slot !== 2'd3) begin
            bad++;
            $display("FAIL wr_issue: got cnt %0d at %0d slot %0d want 1 3 3",
                     we_cnt, we_at, we_slot);
        end
        total++;
        if (we_addr !== 15'h1234 || we_data !== 8'ha5) begin
            bad++;
            $display("FAIL wr_bus: got %h %h want 1234 a5", we_addr, we_data);
        end
        total++;
        if (ack_at != 5) begin
            bad++;
            $display("FAIL wr_ack: got step %0d want 5", ack_at);
        end
        total++;
        if (cpu_rdata !== 8'h00) begin
            bad++;
            $display("FAIL wr_rdata_hold: got %h want 00", cpu_rdata);
        end
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        got = 0;
        for (int i = 0; i < 12 && got == 0; i++) begin
            step();
            if (cpu_ack) got = 1;
        end
        cpu_req = 1'b0;
        total++;
        if (got != 1 || cpu_rdata !== 8'ha5) begin
            bad++;
            $display("FAIL rd_back: got ack %0d data %h want 1 a5",
                     got, cpu_rdata);
        end
    endtask

    task automatic test_slot_pulse();
        name_addr = 15'h0002;
        pat_addr = 15'h0003;
        wait_slot(0);
        slot_en = 1'b1;
        step();
        slot_en = 1'b0;
        step();
        total++;
        if (slot !== 2'd0 || name_vld !== 1'b0) begin
            bad++;
            $display("FAIL pulse_hold: got slot %0d nvld %b want 0 0",
                     slot, name_vld);
        end
        slot_en = 1'b1;
        step();
        total++;
        if (slot !== 2'd1 || name_vld !== 1'b1 || name_data !== 8'h32) begin
            bad++;
            $display("FAIL pulse_name: got slot %0d vld %b data %h want 1 1 32",
                     slot, name_vld, name_data);
        end
        slot_en = 1'b0;
        step();
        total++;
        if (slot !== 2'd1 || pat_vld !== 1'b0 || name_vld !== 1'b0) begin
            bad++;
            $display("FAIL pulse_gap: got slot %0d pvld %b nvld %b want 1 0 0",
                     slot, pat_vld, name_vld);
        end
        slot_en = 1'b1;
        step();
        total++;
        if (slot !== 2'd2 || pat_vld !== 1'b1 || pat_data !== 8'h43) begin
            bad++;
            $display("FAIL pulse_pat: got slot %0d vld %b data %h want 2 1 43",
                     slot, pat_vld, pat_data);
        end
    endtask

    task automatic test_disp_toggle();
        attr_addr = 15'h0001;
        wait_slot(1);
        step();
        disp_en = 1'b0;
        step();
        total++;
        if (slot !== 2'd2 || ram_addr !== 15'h0001) begin
            bad++;
            $display("FAIL tog_attr_issue: got slot %0d addr %h want 2 0001",
                     slot, ram_addr);
        end
        step();
        step();
        total++;
        if (attr_vld !== 1'b1 || attr_data !== 8'h21) begin
            bad++;
            $display("FAIL tog_attr_fetch: got vld %b data %h want 1 21",
                     attr_vld, attr_data);
        end
        total++;
        if (ram_addr !== 15'h0001) begin
            bad++;
            $display("FAIL tog_no_name: got addr %h want 0001", ram_addr);
        end
        step();
        step();
        total++;
        if (name_vld !== 1'b0) begin
            bad++;
            $display("FAIL tog_name_vld: got %b want 0", name_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bexp [4];
        int k;
        int last;
        int vld_seen;
        int we_seen;
        bexp = '{8'h10, 8'h21, 8'h32, 8'h43};
        k = 0;
        last = -1;
        vld_seen = 0;
        we_seen = 0;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 15'h0000;
        for (int i = 0; i < 40; i++) begin
            step();
            if (name_vld || pat_vld || attr_vld) vld_seen++;
            if (ram_we) we_seen++;
            if (cpu_ack) begin
                total++;
                if (k < 4 && cpu_rdata !== bexp[k]) begin
                    bad++;
                    $display("FAIL b2b_data[%0d]: got %h want %h",
                             k, cpu_rdata, bexp[k]);
                end
                if (k > 0) begin
                    total++;
                    if (i - last != 4) begin
                        bad++;
                        $display("FAIL b2b_gap[%0d]: got %0d want 4",
                                 k, i - last);
                    end
                end
                last = i;
                k++;
                if (k < 4) cpu_addr = 15'(k);
                else cpu_req = 1'b0;
            end
        end
        total++;
        if (k != 4) begin
            bad++;
            $display("FAIL b2b_acks: got %0d want 4", k);
        end
        total++;
        if (vld_seen != 0 || we_seen != 0) begin
            bad++;
            $display("FAIL b2b_quiet: got vld %0d we %0d want 0 0",
                     vld_seen, we_seen);
        end
    endtask

    initial begin
        mem[15'h0000] = 8'h10;
        mem[15'h0001] = 8'h21;
        mem[15'h0002] = 8'h32;
        mem[15'h0003] = 8'h43;
        mem[15'h0100] = 8'h41;
        mem[15'h2208] = 8'h3c;
        mem[15'h4100] = 8'h1f;
        mem[15'h1234] = 8'h00;
        test_reset();
        test_display();
        test_cpu_write_read();
        test_slot_pulse();
        test_disp_toggle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Time-division scheduler for the single-port 32K×8 VRAM (spram32k8) shared by display character fetch and the CPU port.
- Each 4-slot fetch cycle runs name, pattern, attribute, then one CPU slot.
- Runs a registered issue/capture pipeline around the synchronous RAM and returns fetched bytes with strobes.
- Gives the CPU side a req/ack handshake for single-byte reads and writes, replacing ad-hoc per-state RAM muxing in the VDP.

Parameters:
- ADDR_WIDTH, 15, VRAM address width.
- DATA_WIDTH, 8, VRAM data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted while low; clears all state immediately.
- slot_en  in  1  slot advance enable (dot-rate strobe); one slot issued per clk with slot_en high.
- disp_en  in  1  display fetch enable; low gives all four slots to the CPU.
- slot  out  2  slot number issued on the most recent slot_en edge (0 name, 1 pattern, 2 attr, 3 CPU).
- name_addr, pat_addr, attr_addr  in  ADDR_WIDTH each  display fetch addresses, sampled at their slot's issue edge.
- name_data, pat_data, attr_data  out  DATA_WIDTH each  captured fetch bytes; hold until the next capture.
- name_vld, pat_vld, attr_vld  out  1 each  one-clk pulse when the matching *_data updates.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1 = write, 0 = read; held with req.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-clk pulse: access complete.
- cpu_rdata  out  DATA_WIDTH  read byte, valid with cpu_ack; held afterwards.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM output; valid the clk after the edge that sampled ram_addr.

Behaviour:
- Reset values: all outputs 0, slot counter 0, no request in flight.
  - Reset mid-access drops the access; no ack is issued and the requester must re-request.
  - A write already presented to the RAM may or may not land.
- Slot counter: 2-bit, increments (wraps 3→0) on each clk with slot_en=1.
- Issue stage, on a clk with slot_en=1, for the current counter value s:
  - ram_addr, ram_we and ram_wdata are registered.
  - A tag (s, kind) is registered.
  - slot <= s.
- slot_en=0: no issue; ram_we <= 0; ram_addr holds.
- Display slots: s=0,1,2 with the display-enable latch set.
  - ram_addr <= name_addr / pat_addr / attr_addr; ram_we <= 0.
  - pat_addr may depend combinationally on name_data captured in the preceding cycles; the arbiter does not care.
- CPU slot: s=3, or any s while the display-enable latch is clear.
  - Grant if cpu_req=1, no CPU access in flight, and cpu_ack=0 this clk.
  - Grant: ram_addr <= cpu_addr, ram_we <= cpu_we, ram_wdata <= cpu_wdata; mark in flight.
  - No grant: ram_we <= 0, ram_addr holds.
- Display-enable latch: loaded from disp_en on the issue edge of s=3, so a change applies from the next s=0. Reset value 0.
- Pipeline:
  - Tag is delayed one more clk (RAM sample edge).
  - On the following edge the capture stage loads ram_rdata into the tagged destination and pulses its *_vld / cpu_ack.
  - Latency: issue edge E → data/strobe valid after edge E+2, independent of slot_en cadence.
- Writes: ack follows the same 2-clk latency; cpu_rdata is unchanged on write ack.
- Handshake rules:
  - Requester holds cpu_req/we/addr/wdata stable until cpu_ack.
  - Requester may re-assert or keep req high for a new access after the ack clk.
  - At most one CPU access in flight; in-flight clears on the ack edge.
- Simultaneous events: display slots are never displaced by the CPU. A request arriving during s=0..2 waits for the next eligible CPU slot.
- Starvation bound with disp_en=1: grant within 4 slot_en strobes of req.

Test Plan:
- Reset low mid-run: all outputs 0 immediately. Release with slot_en=1 continuous: slot sequence 0,1,2,3,0.
- disp_en=1; RAM preloaded [0x0100]=0x41, [0x2208]=0x3C, [0x4100]=0x1F; name_addr=0x0100, pat_addr=0x2208, attr_addr=0x4100.
  - Expect name_data=0x41, pat_data=0x3C, attr_data=0x1F, each vld pulse 2 clk after its issue edge.
- CPU write: cpu_req=1, cpu_we=1, cpu_addr=0x1234, cpu_wdata=0xA5, asserted at s=0.
  - Expect issue in slot 3 only, ram_we=1 for exactly one clk, cpu_ack 2 clk later.
  - A following read of 0x1234 returns cpu_rdata=0xA5.
- disp_en=0 with back-to-back reads of 0x0000..0x0003 (req held high): one access per ack.
  - Expect four acks, no *_vld pulses, no double-issue of any address.
- slot_en pulsing every 2 clk: slot advances only on enabled edges, and data latency stays 2 clk from issue.
- Toggle disp_en at s=1: change takes effect at the next s=0, and the current cycle's remaining slots are unaffected.
